// File: rtl/and4_vector_checker.sv
// Stimulus-and-check stage for a 4-input AND tree: walks a range of vectors
// over a..d, samples the tree output after a settle interval, and tallies mismatches.
module and4_vector_checker #(
  parameter logic [3:0] START_VEC     = 4'd0,
  parameter logic [3:0] END_VEC       = 4'd15,
  parameter int         SETTLE_CYCLES = 3,
  parameter int         CNT_W         = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             out_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       first_fail
);

  // A settle interval of 0 would never sample, so it degenerates to 1.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SC_W = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [3:0]       ff_q, ff_d;

  logic             exp_bit;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      vec_q   <= 4'h0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    exp_bit  = &vec_q;
    // Case inequality so an unknown tree output is never taken as a match.
    mismatch = (out_in !== exp_bit);
    err_next = err_q;
    if (mismatch && (err_q != {CNT_W{1'b1}})) begin
      err_next = err_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = START_VEC;
          cnt_d   = SC_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = 4'h0;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SC_W'(1);
        end else begin
          err_d = err_next;
          if (mismatch) begin
            fv_d = 1'b1;
            if (!fv_q) ff_d = vec_q;
          end
          if (vec_q == END_VEC) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            vec_d = vec_q + 4'd1;
            cnt_d = SC_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a          = vec_q[3];
  assign b          = vec_q[2];
  assign c          = vec_q[1];
  assign d          = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_and4_vector_checker.sv
// Bench for and4_vector_checker: four parameterisations, each driving a delayed
// AND-tree model (11-unit worst path) or bench-controlled out_in values.
module tb_and4_vector_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear;
  logic st0, st1, st2, st3;
  logic [1:0] mode0;
  logic mode1;
  logic rnd0;

  int checks = 0;
  int failures = 0;

  // u0: defaults
  logic a0, b0, c0, d0, busy0, done0, pass0, fv0, out0, ab0, cd0, t0;
  logic [4:0] err0;
  logic [3:0] ff0;
  // u1: SETTLE_CYCLES=1, CNT_W=3
  logic a1, b1, c1, d1, busy1, done1, pass1, fv1, out1, ab1, cd1, t1;
  logic [2:0] err1;
  logic [3:0] ff1;
  // u2: wrap 14..1, SETTLE_CYCLES=2
  logic a2, b2, c2, d2, busy2, done2, pass2, fv2, ab2, cd2, t2;
  logic [4:0] err2;
  logic [3:0] ff2;
  // u3: single vector 5, SETTLE_CYCLES=0
  logic a3, b3, c3, d3, busy3, done3, pass3, fv3, ab3, cd3, t3;
  logic [4:0] err3;
  logic [3:0] ff3;

  // Distributed-delay tree models: 5 + 6 = 11 units worst path.
  assign #5 ab0 = a0 & b0;
  assign #5 cd0 = c0 & d0;
  assign #6 t0  = ab0 & cd0;
  assign #5 ab1 = a1 & b1;
  assign #5 cd1 = c1 & d1;
  assign #6 t1  = ab1 & cd1;
  assign #5 ab2 = a2 & b2;
  assign #5 cd2 = c2 & d2;
  assign #6 t2  = ab2 & cd2;
  assign #5 ab3 = a3 & b3;
  assign #5 cd3 = c3 & d3;
  assign #6 t3  = ab3 & cd3;

  assign out0 = (mode0 == 2'd0) ? t0 : (mode0 == 2'd1) ? 1'b1 : (mode0 == 2'd2) ? 1'b0 : rnd0;
  assign out1 = mode1 ? 1'b1 : t1;

  and4_vector_checker u0 (
    .clock(clock), .clear(clear), .start(st0), .out_in(out0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail(ff0));

  and4_vector_checker #(.SETTLE_CYCLES(1), .CNT_W(3)) u1 (
    .clock(clock), .clear(clear), .start(st1), .out_in(out1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail(ff1));

  and4_vector_checker #(.START_VEC(4'd14), .END_VEC(4'd1), .SETTLE_CYCLES(2)) u2 (
    .clock(clock), .clear(clear), .start(st2), .out_in(t2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail(ff2));

  and4_vector_checker #(.START_VEC(4'd5), .END_VEC(4'd5), .SETTLE_CYCLES(0)) u3 (
    .clock(clock), .clear(clear), .start(st3), .out_in(t3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3), .first_fail(ff3));

  typedef struct {
    logic [1:0] mode;
    int         err;
    int         ff;
    int         fv;
    int         pass;
  } run_vec_t;

  run_vec_t tbl[3];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full default-parameter run: vector k held for 3 cycles, done at E0+48.
  task automatic run_u0(input int req_err, input int req_ff, input int req_fv, input int req_pass);
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    chk("u0_start_busy", int'(busy0), 1);
    chk("u0_start_done", int'(done0), 0);
    chk("u0_start_err", int'(err0), 0);
    chk("u0_start_fv", int'(fv0), 0);
    chk("u0_start_vec", int'({a0, b0, c0, d0}), 0);
    for (int t = 1; t <= 48; t++) begin
      tick();
      if (t < 48) begin
        chk("u0_vec", int'({a0, b0, c0, d0}), t / 3);
        chk("u0_not_done", int'(done0), 0);
      end
    end
    chk("u0_done", int'(done0), 1);
    chk("u0_end_busy", int'(busy0), 0);
    chk("u0_end_vec", int'({a0, b0, c0, d0}), 15);
    chk("u0_err", int'(err0), req_err);
    chk("u0_fv", int'(fv0), req_fv);
    if (req_fv != 0) chk("u0_first_fail", int'(ff0), req_ff);
    chk("u0_pass", int'(pass0), req_pass);
  endtask

  // Random out_in; reference tallies mismatches from the vector index at each sample.
  task automatic run_u0_random();
    int m_err;
    int m_ff;
    m_err = 0;
    m_ff = -1;
    mode0 = 2'd3;
    rnd0 = 1'($urandom_range(1, 0));
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    for (int t = 1; t <= 48; t++) begin
      logic cur;
      cur = 1'($urandom_range(1, 0));
      rnd0 = cur;
      tick();
      if (t % 3 == 0) begin
        int k;
        k = t / 3 - 1;
        if (cur != (k == 15)) begin
          m_err++;
          if (m_ff < 0) m_ff = k;
        end
      end
    end
    chk("rnd_done", int'(done0), 1);
    chk("rnd_err", int'(err0), m_err);
    chk("rnd_fv", int'(fv0), (m_ff >= 0) ? 1 : 0);
    if (m_ff >= 0) chk("rnd_first_fail", int'(ff0), m_ff);
    chk("rnd_pass", int'(pass0), (m_err == 0) ? 1 : 0);
  endtask

  initial begin
    tbl[0] = '{mode: 2'd0, err: 0,  ff: 0,  fv: 0, pass: 1};
    tbl[1] = '{mode: 2'd1, err: 15, ff: 0,  fv: 1, pass: 0};
    tbl[2] = '{mode: 2'd2, err: 1,  ff: 15, fv: 1, pass: 0};

    clear = 1'b1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    mode0 = 2'd0; mode1 = 1'b0; rnd0 = 1'b0;
    #2 clear = 1'b0;
    #20;
    chk("rst_vec", int'({a0, b0, c0, d0}), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_fv", int'(fv0), 0);
    chk("rst_ff", int'(ff0), 0);
    #10 clear = 1'b1;
    tick();
    chk("idle_busy", int'(busy0), 0);

    for (int i = 0; i < 3; i++) begin
      mode0 = tbl[i].mode;
      run_u0(tbl[i].err, tbl[i].ff, tbl[i].fv, tbl[i].pass);
    end

    for (int r = 0; r < 4; r++) run_u0_random();

    // Mid-run: start ignored while busy, then asynchronous clear at vector 5.
    mode0 = 2'd1;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      if (t == 7) st0 = 1'b1;
      if (t == 8) st0 = 1'b0;
      tick();
    end
    chk("mid_vec", int'({a0, b0, c0, d0}), 5);
    chk("mid_err", int'(err0), 5);
    #3 clear = 1'b0;
    #1;
    chk("clr_vec", int'({a0, b0, c0, d0}), 0);
    chk("clr_busy", int'(busy0), 0);
    chk("clr_err", int'(err0), 0);
    chk("clr_fv", int'(fv0), 0);
    #1 clear = 1'b1;
    tick();
    chk("post_clr_idle", int'(busy0), 0);
    mode0 = 2'd0;
    tick();
    tick();
    run_u0(0, 0, 0, 1);

    // SETTLE_CYCLES=1 with healthy tree: each sample sees the previous vector's 0.
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 15) chk("u1_not_done", int'(done1), 0);
    end
    chk("u1_done", int'(done1), 1);
    chk("u1_err", int'(err1), 1);
    chk("u1_fv", int'(fv1), 1);
    chk("u1_first_fail", int'(ff1), 15);
    chk("u1_pass", int'(pass1), 0);
    // Tied high: 15 mismatches saturate a 3-bit count.
    mode1 = 1'b1;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int t = 1; t <= 16; t++) tick();
    chk("u1_sat_err", int'(err1), 7);
    chk("u1_sat_ff", int'(ff1), 0);
    chk("u1_sat_busy", int'(busy1), 0);
    chk("u1_sat_pass", int'(pass1), 0);

    // Wrapping range 14,15,0,1 with 2-cycle settle.
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("u2_v14", int'({a2, b2, c2, d2}), 14);
    tick(); tick();
    chk("u2_v15", int'({a2, b2, c2, d2}), 15);
    tick(); tick();
    chk("u2_v0", int'({a2, b2, c2, d2}), 0);
    tick(); tick();
    chk("u2_v1", int'({a2, b2, c2, d2}), 1);
    tick();
    chk("u2_not_done", int'(done2), 0);
    tick();
    chk("u2_done", int'(done2), 1);
    chk("u2_pass", int'(pass2), 1);
    chk("u2_err", int'(err2), 0);
    chk("u2_fv", int'(fv2), 0);
    chk("u2_ff", int'(ff2), 0);

    // Single vector, zero settle treated as one, start held high re-runs.
    st3 = 1'b1;
    tick();
    chk("u3_busy0", int'(busy3), 1);
    chk("u3_vec", int'({a3, b3, c3, d3}), 5);
    tick();
    chk("u3_done1", int'(done3), 1);
    chk("u3_busy1", int'(busy3), 0);
    chk("u3_pass", int'(pass3), 1);
    tick();
    chk("u3_rerun_busy", int'(busy3), 1);
    chk("u3_rerun_done", int'(done3), 0);
    tick();
    chk("u3_done2", int'(done3), 1);
    st3 = 1'b0;
    tick();
    chk("u3_hold_done", int'(done3), 1);
    chk("u3_err", int'(err3), 0);
    chk("u3_fv", int'(fv3), 0);
    chk("u3_ff", int'(ff3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
